// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shift register.
// Back-to-back bytes leave the line with no idle gap between the stop bit and the next start bit.
`timescale 1ns/1ps
module uart_tx #(
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned CLOCK_RATE = 100_000_000
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_data_vld,
  output logic       tx_rdy,
  output logic       tx_busy,
  output logic       txd_tx
);

  localparam int unsigned DIVISOR = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_divisor_check
      $error("uart_tx: CLOCK_RATE / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic             r_txd;
  logic             r_rdy;
  logic             r_busy;

  logic w_accept;
  logic w_bit_end;

  // r_rdy always mirrors an empty holding register, so acceptance and transfer never coincide.
  assign w_accept  = tx_data_vld & r_rdy;
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_txd       <= 1'b1;
      r_rdy       <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
        r_rdy       <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (r_hold_full) begin
            r_state     <= START;
            r_shift     <= r_hold;
            r_hold_full <= 1'b0;
            r_rdy       <= 1'b1;
            r_txd       <= 1'b0;
            r_baud_cnt  <= '0;
            r_busy      <= 1'b1;
          end else begin
            r_busy <= w_accept;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_state    <= DATA;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_txd      <= r_shift[0];
            r_shift    <= r_shift >> 1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            // A byte already held chains straight into the next start bit.
            if (r_hold_full) begin
              r_state     <= START;
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_rdy       <= 1'b1;
              r_txd       <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= w_accept;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_rdy  = r_rdy;
  assign tx_busy = r_busy;
  assign txd_tx  = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIVISOR=10: frame shape, latency, chaining, backpressure, reset abort.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk_tx;
  logic       rst_clk_tx;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic       tx_rdy;
  logic       tx_busy;
  logic       txd_tx;

  int checks   = 0;
  int failures = 0;

  uart_tx #(
    .BAUD_RATE (100_000),
    .CLOCK_RATE(1_000_000)
  ) dut (
    .clk_tx     (clk_tx),
    .rst_clk_tx (rst_clk_tx),
    .tx_data    (tx_data),
    .tx_data_vld(tx_data_vld),
    .tx_rdy     (tx_rdy),
    .tx_busy    (tx_busy),
    .txd_tx     (txd_tx)
  );

  initial clk_tx = 1'b0;
  always #5 clk_tx = ~clk_tx;

  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a byte from an idle-ready state: accept on E0, transfer on E1.
  task automatic send_byte(input logic [7:0] b);
    chk("rdy_before_send", {31'd0, tx_rdy}, 32'd1);
    tx_data     = b;
    tx_data_vld = 1'b1;
    tick();
    tx_data_vld = 1'b0;
    chk("rdy_after_accept", {31'd0, tx_rdy}, 32'd0);
    chk("busy_after_accept", {31'd0, tx_busy}, 32'd1);
    chk("txd_idle_at_accept", {31'd0, txd_tx}, 32'd1);
    tick();
    chk("txd_start_after_transfer", {31'd0, txd_tx}, 32'd0);
    chk("rdy_after_transfer", {31'd0, tx_rdy}, 32'd1);
  endtask

  // Watch 100 cycles starting at the first start-bit cycle; also acts as a mid-bit receiver.
  task automatic check_frame(input logic [7:0] exp, input bit noise,
                             output int lows, output int busy_cnt);
    logic [9:0] frame;
    logic [9:0] rx;
    bit         bad;
    frame    = {1'b1, exp, 1'b0};
    rx       = '0;
    lows     = 0;
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (txd_tx !== frame[k]) bad = 1'b1;
        if (txd_tx === 1'b0) lows++;
        if (tx_busy === 1'b1) busy_cnt++;
        if (c == 5) rx[k] = txd_tx;
        if (k * 10 + c >= 1) begin
          if (noise && (k * 10 + c < 90)) begin
            tx_data     = 8'($urandom);
            tx_data_vld = 1'b1;
          end else begin
            tx_data_vld = 1'b0;
          end
        end
        tick();
      end
      chk($sformatf("frame_%02h_bit%0d", exp, k), {31'd0, bad}, 32'd0);
    end
    chk($sformatf("rx_start_%02h", exp), {31'd0, rx[0]}, 32'd0);
    chk($sformatf("rx_byte_%02h", exp), {24'd0, rx[8:1]}, {24'd0, exp});
    chk($sformatf("rx_stop_%02h", exp), {31'd0, rx[9]}, 32'd1);
  endtask

  initial begin
    int  lows;
    int  busy_cnt;
    bit  bad_txd, bad_rdy, bad_busy;

    rst_clk_tx  = 1'b1;
    tx_data     = 8'h77;
    tx_data_vld = 1'b1;
    repeat (3) tick();
    chk("reset_txd", {31'd0, txd_tx}, 32'd1);
    chk("reset_rdy", {31'd0, tx_rdy}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    tx_data_vld = 1'b0;
    rst_clk_tx  = 1'b0;
    repeat (2) tick();
    chk("no_capture_in_reset_txd", {31'd0, txd_tx}, 32'd1);
    chk("no_capture_in_reset_busy", {31'd0, tx_busy}, 32'd0);

    // Idle line for 1000 cycles
    bad_txd = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      if (txd_tx !== 1'b1) bad_txd = 1;
      if (tx_rdy !== 1'b1) bad_rdy = 1;
      if (tx_busy !== 1'b0) bad_busy = 1;
      tick();
    end
    chk("idle_txd", {31'd0, bad_txd}, 32'd0);
    chk("idle_rdy", {31'd0, bad_rdy}, 32'd0);
    chk("idle_busy", {31'd0, bad_busy}, 32'd0);

    // Single byte 0xA5
    send_byte(8'hA5);
    check_frame(8'hA5, 1'b0, lows, busy_cnt);
    chk("a5_busy_cycles", 32'(1 + busy_cnt), 32'd101);
    chk("a5_lows", 32'(lows), 32'd50);
    chk("a5_end_txd", {31'd0, txd_tx}, 32'd1);
    chk("a5_end_busy", {31'd0, tx_busy}, 32'd0);
    chk("a5_end_rdy", {31'd0, tx_rdy}, 32'd1);
    repeat (5) tick();

    // Back-to-back 0x55 then 0x0F
    send_byte(8'h55);
    tx_data     = 8'h0F;
    tx_data_vld = 1'b1;
    check_frame(8'h55, 1'b0, lows, busy_cnt);
    chk("b2b_no_gap_txd", {31'd0, txd_tx}, 32'd0);
    chk("b2b_rdy_after_chain", {31'd0, tx_rdy}, 32'd1);
    check_frame(8'h0F, 1'b0, lows, busy_cnt);
    chk("b2b_end_busy", {31'd0, tx_busy}, 32'd0);
    repeat (5) tick();

    // Backpressure: 0xC3 held while noisy offers are ignored
    send_byte(8'h3C);
    tx_data     = 8'hC3;
    tx_data_vld = 1'b1;
    check_frame(8'h3C, 1'b1, lows, busy_cnt);
    check_frame(8'hC3, 1'b0, lows, busy_cnt);
    chk("bp_end_busy", {31'd0, tx_busy}, 32'd0);
    repeat (5) tick();

    // Extremes
    send_byte(8'h00);
    check_frame(8'h00, 1'b0, lows, busy_cnt);
    chk("x00_lows", 32'(lows), 32'd90);
    repeat (3) tick();
    send_byte(8'hFF);
    check_frame(8'hFF, 1'b0, lows, busy_cnt);
    chk("xff_lows", 32'(lows), 32'd10);
    repeat (3) tick();

    // Reset during data bit 3 of 0x00, with 0xFF held
    send_byte(8'h00);
    tx_data     = 8'hFF;
    tx_data_vld = 1'b1;
    tick();
    tx_data_vld = 1'b0;
    repeat (43) tick();
    chk("mid_bit3_txd", {31'd0, txd_tx}, 32'd0);
    chk("mid_hold_full_rdy", {31'd0, tx_rdy}, 32'd0);
    rst_clk_tx = 1'b1;
    tick();
    rst_clk_tx = 1'b0;
    chk("abort_txd", {31'd0, txd_tx}, 32'd1);
    chk("abort_rdy", {31'd0, tx_rdy}, 32'd1);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    bad_txd = 0; bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd_tx !== 1'b1) bad_txd = 1;
      if (tx_busy !== 1'b0) bad_busy = 1;
      tick();
    end
    chk("abort_held_never_sent", {31'd0, bad_txd}, 32'd0);
    chk("abort_stays_idle", {31'd0, bad_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-002 The block SHALL have parameter CLOCK_RATE, default 100_000_000, clk_tx frequency in Hz.
REQ-003 The block SHALL have port clk_tx, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_clk_tx, input, 1 bit, reset; synchronous to clk_tx and active-high.
REQ-005 The block SHALL have port tx_data, input, 8 bits, byte to transmit.
REQ-006 The block SHALL have port tx_data_vld, input, 1 bit, high when tx_data holds a byte offered for transmission.
REQ-007 The block SHALL have port tx_rdy, output, 1 bit, registered; high when the holding register is empty and a byte can be accepted.
REQ-008 The block SHALL have port tx_busy, output, 1 bit, registered; high while a frame is on the line or the holding register is full.
REQ-009 The block SHALL have port txd_tx, output, 1 bit, registered serial line; idle high.

Function
REQ-010 The block SHALL define DIVISOR = CLOCK_RATE / BAUD_RATE with integer truncation (868 at defaults); DIVISOR < 2 SHALL be a compile-time error.
REQ-011 The frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 Each bit SHALL be driven on txd_tx for exactly DIVISOR clk_tx cycles; a full frame SHALL last 10*DIVISOR cycles.
REQ-013 A byte SHALL be accepted on a rising edge where tx_data_vld=1 and tx_rdy=1; tx_data is captured into a one-byte holding register and tx_rdy SHALL be 0 from the next cycle.
REQ-014 tx_data_vld while tx_rdy=0 SHALL be ignored; no byte captured, no state change.
REQ-015 The state machine SHALL have states IDLE, START, DATA, STOP: IDLE->START when holding full; START->DATA after DIVISOR cycles; DATA->STOP after 8*DIVISOR cycles; STOP->START if holding full on the last STOP cycle, else STOP->IDLE.
REQ-016 On entering START the holding register SHALL be moved into the shift register, the holding register marked empty, and tx_rdy SHALL be 1 from the next cycle.
REQ-017 Latency: accept on edge E0 -> transfer on edge E1 -> txd_tx=0 from E1 onward (first low cycle immediately after E1), when the block was IDLE.
REQ-018 Back-to-back: if the holding register is full at the end of STOP, the next START bit SHALL follow with zero idle cycles.
REQ-019 A bit counter SHALL count 0..7 in DATA; the baud counter SHALL count 0..DIVISOR-1 and reload to 0 on every bit boundary and on entry to START.
REQ-020 tx_busy SHALL be 1 in START, DATA, STOP or when the holding register is full; 0 only in IDLE with the holding register empty.
REQ-021 In IDLE txd_tx SHALL be 1.
REQ-022 tx_data changes after acceptance SHALL NOT affect the frame in progress or the held byte.

Reset
REQ-023 While rst_clk_tx=1 at a rising edge: state IDLE, txd_tx=1, tx_rdy=1, tx_busy=0, holding register empty, counters 0.
REQ-024 tx_data_vld SHALL be ignored on edges where rst_clk_tx=1.
REQ-025 Reset mid-frame SHALL abort the frame (txd_tx=1 from the next cycle) and discard any held byte; no partial resumption.

Verification (bench uses CLOCK_RATE=1_000_000, BAUD_RATE=100_000, DIVISOR=10)
REQ-026 Single byte: send 0xA5 from IDLE -> txd_tx 0 for 10 cycles, then 1,0,1,0,0,1,0,1 each 10 cycles, then 1 for 10 cycles; tx_busy high for 101 cycles from acceptance.
REQ-027 Back-to-back: offer 0x55 then 0x0F as soon as tx_rdy returns high -> two contiguous 100-cycle frames, no idle gap between stop and start.
REQ-028 Backpressure: hold tx_data_vld=1 with changing tx_data while tx_rdy=0 -> only the value present on the accepting edge is transmitted.
REQ-029 Reset mid-DATA: assert rst_clk_tx for 1 cycle during bit 3 of 0x00 -> txd_tx=1, tx_rdy=1, tx_busy=0 next cycle; holding byte never sent.
REQ-030 Extremes: send 0x00 and 0xFF -> line low for 90 cycles then high 10; line low 10 then high 90 (frame framing checked by a reference UART receiver model).
REQ-031 Idle: no tx_data_vld for 1000 cycles after reset -> txd_tx=1, tx_rdy=1, tx_busy=0 throughout.
